// File: rtl/decoder_16_seq.sv
// -----------------------------------------------------------------------------
// decoder_16_seq
//   Sequenced 4-to-16 one-hot decoder. A 4-bit code is accepted through a
//   valid/ready handshake. The matching one-hot line is driven for
//   HOLD_CYCLES cycles. The output is then forced to zero for GAP_CYCLES
//   cycles before the next code can be taken.
//
//   Handshake: a code transfers on a rising clk edge where code_valid and
//   code_ready are both high. code_ready is high only when en is high and
//   the FSM is IDLE. Valid held while not ready is ignored, and the code is
//   not latched.
//
// Parameters
//   HOLD_CYCLES  cycles the one-hot line stays asserted (0 behaves as 1)
//   GAP_CYCLES   cycles of forced all-zero output after each hold (0 = none)
//   CNT_W        width of the shared hold/gap down-counter
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           block enable; low aborts a hold/gap in progress
//   code_valid   code presented
//   code[3:0]    index of the line to drive
//   code_ready   en && IDLE (combinational)
//   y[15:0]      one-hot decoded output (registered)
//   busy         high in DRIVE or GAP (registered)
//   done         one-cycle pulse when a hold completes normally (registered)
//   dbg_state_o  current FSM state (0 IDLE, 1 DRIVE, 2 GAP)
//
// Configuration macro
//   DECODER_TRISTATE_EN  when defined, y floats (16'hzzzz) whenever en=0.
//                        FSM and counter behaviour is unchanged.
// -----------------------------------------------------------------------------
module decoder_16_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        code_valid,
    input  logic [3:0]  code,
    output logic        code_ready,
    output logic [15:0] y,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // A zero hold would give no visible pulse, so it is stretched to one cycle.
    localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int CNT_SPAN = 2 ** CNT_W;

    // The counter counts down to zero, so it is loaded with length-1.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

    if (HOLD_CYCLES > CNT_SPAN) begin : g_hold_cfg_err
        $error("decoder_16_seq: HOLD_CYCLES=%0d does not fit CNT_W=%0d", HOLD_CYCLES, CNT_W);
    end
    if (GAP_CYCLES > CNT_SPAN || GAP_CYCLES < 0) begin : g_gap_cfg_err
        $error("decoder_16_seq: GAP_CYCLES=%0d does not fit CNT_W=%0d", GAP_CYCLES, CNT_W);
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [15:0]        y_q,     y_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            y_q     <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;   // done is a single-cycle pulse

        case (state_q)
            S_IDLE: begin
                if (en && code_valid) begin
                    state_d = S_DRIVE;
                    cnt_d   = HOLD_LOAD;
                    y_d     = 16'h0001 << code;
                    busy_d  = 1'b1;
                end
            end

            S_DRIVE: begin
                if (!en) begin
                    // Abort: drop everything, no done pulse.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    y_d     = 16'h0000;
                    busy_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    y_d    = 16'h0000;
                    done_d = 1'b1;
                    if (HAS_GAP) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        // No gap: IDLE in the done cycle, so a new code can
                        // be taken there, leaving one zero cycle.
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_GAP: begin
                if (!en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    y_d     = 16'h0000;
                    busy_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                y_d     = 16'h0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign code_ready  = en && (state_q == S_IDLE);
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

`ifdef DECODER_TRISTATE_EN
    // Release the shared bus while disabled; the register keeps its value.
    assign y = en ? y_q : 16'hzzzz;
`else
    assign y = y_q;
`endif

endmodule

// File: tb/tb_decoder_16_seq.sv
// Testbench for decoder_16_seq. Three instances with different hold/gap
// settings share one set of inputs; each is checked every cycle against a
// timestamp-based model of when its line, busy and done must be active.
module tb_decoder_16_seq;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        code_valid;
    logic [3:0]  code;

    wire  [15:0] y_w     [3];
    wire         ready_w [3];
    wire         busy_w  [3];
    wire         done_w  [3];
    wire  [1:0]  st_w    [3];

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_on  = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    decoder_16_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .code_valid(code_valid), .code(code),
        .code_ready(ready_w[0]), .y(y_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .dbg_state_o(st_w[0]));

    decoder_16_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .code_valid(code_valid), .code(code),
        .code_ready(ready_w[1]), .y(y_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .dbg_state_o(st_w[1]));

    decoder_16_seq #(.HOLD_CYCLES(0), .GAP_CYCLES(2), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .code_valid(code_valid), .code(code),
        .code_ready(ready_w[2]), .y(y_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .dbg_state_o(st_w[2]));

    // ---------------- model ----------------
    // Effective hold length (0 behaves as 1) and gap length per instance.
    function automatic int hold_of(int i);
        case (i)
            0: return 4;
            1: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int gap_of(int i);
        case (i)
            0: return 1;
            1: return 0;
            default: return 2;
        endcase
    endfunction

    // Cycle k = the interval after the k-th rising edge. An accept at edge a
    // gives the line in cycles a..a+H-1, done in a+H, busy in a..a+H+G-1.
    int         cyc = 0;
    bit         active [3];
    int         acc    [3];
    logic [3:0] mcode  [3];

    function automatic bit busy_at(int i, int c);
        return active[i] && (c >= acc[i]) && (c < acc[i] + hold_of(i) + gap_of(i));
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                active[i] <= 1'b0;
            end else if (busy_at(i, cyc)) begin
                if (!en) active[i] <= 1'b0;
            end else if (en && code_valid) begin
                active[i] <= 1'b1;
                acc[i]    <= cyc + 1;
                mcode[i]  <= code;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [15:0] idle_y();
`ifdef DECODER_TRISTATE_EN
        return en ? 16'h0000 : 16'hzzzz;
`else
        return 16'h0000;
`endif
    endfunction

    always @(negedge clk) begin
        if (cmp_on && rst_n) begin
            for (int i = 0; i < 3; i++) begin
                logic [15:0] ey;
                logic        eb, ed;
                eb = busy_at(i, cyc);
                ed = active[i] && (cyc == acc[i] + hold_of(i));
                ey = (active[i] && cyc >= acc[i] && cyc < acc[i] + hold_of(i))
                     ? (16'h0001 << mcode[i]) : 16'h0000;
`ifdef DECODER_TRISTATE_EN
                if (!en) ey = 16'hzzzz;
`endif
                check($sformatf("y[%0d]", i),     y_w[i],            ey);
                check($sformatf("busy[%0d]", i),  {15'd0, busy_w[i]},  {15'd0, eb});
                check($sformatf("done[%0d]", i),  {15'd0, done_w[i]},  {15'd0, ed});
                check($sformatf("ready[%0d]", i), {15'd0, ready_w[i]}, {15'd0, en && !eb});
                if (en)
                    check($sformatf("onehot[%0d]", i),
                          {15'd0, ($countones(y_w[i]) <= 1)}, 16'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit e, input bit v, input logic [3:0] c);
        @(posedge clk);
        #2;
        en         = e;
        code_valid = v;
        code       = c;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!busy_w[0] && !busy_w[1] && !busy_w[2]) break;
        end
        check("idle_wait", {13'd0, busy_w[0], busy_w[1], busy_w[2]}, 16'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; en = 1'b0; code_valid = 1'b0; code = 4'h0;

        // Reset values and code_ready following en while in reset.
        #3;
        check("rst_y",     y_w[0], idle_y());
        check("rst_busy",  {15'd0, busy_w[0]},  16'd0);
        check("rst_done",  {15'd0, done_w[0]},  16'd0);
        check("rst_ready0", {15'd0, ready_w[0]}, 16'd0);
        en = 1'b1;
        #1;
        check("rst_ready1", {15'd0, ready_w[0]}, 16'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cmp_on = 1'b1;

        // Single code 0xA, HOLD=4 GAP=1.
        drive(1, 1, 4'hA);
        drive(1, 0, 4'($urandom_range(0, 15)));
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("t1_y_c%0d", k), y_w[0], 16'h0400);
        end
        @(negedge clk);
        check("t1_done", {15'd0, done_w[0]}, 16'd1);
        check("t1_y0",   y_w[0], 16'h0000);
        @(negedge clk);
        check("t1_busy_low", {15'd0, busy_w[0]},  16'd0);
        check("t1_ready",    {15'd0, ready_w[0]}, 16'd1);
        wait_idle();

        // Every code in turn; code input scrambled right after the accept.
        for (int c = 0; c < 16; c++) begin
            drive(1, 1, 4'(c));
            drive(1, 0, 4'($urandom_range(0, 15)));
            @(negedge clk);
            check($sformatf("t2_code%0d", c), y_w[0], 16'h0001 << c);
            wait_idle();
        end

        // Back-to-back on the gapless instance, valid held high.
        drive(1, 1, 4'd3);
        drive(1, 1, 4'd7);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_y3", y_w[1], 16'h0008);
        end
        @(negedge clk);
        check("t3_zero", y_w[1], 16'h0000);
        check("t3_done", {15'd0, done_w[1]}, 16'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_y7", y_w[1], 16'h0080);
        end
        drive(1, 0, 4'd0);
        wait_idle();

        // Abort in the second DRIVE cycle, then a normal accept.
        drive(1, 1, 4'd5);
        drive(1, 0, 4'd0);
        @(negedge clk);
        check("t4_y5", y_w[0], 16'h0020);
        drive(0, 0, 4'd0);
        drive(1, 1, 4'd1);
        @(negedge clk);
        check("t4_abort_y",    y_w[0], 16'h0000);
        check("t4_abort_busy", {15'd0, busy_w[0]}, 16'd0);
        check("t4_abort_done", {15'd0, done_w[0]}, 16'd0);
        drive(1, 0, 4'd0);
        @(negedge clk);
        check("t4_y1", y_w[0], 16'h0002);
        wait_idle();

        // Asynchronous reset in the middle of a hold.
        drive(1, 1, 4'd9);
        drive(1, 0, 4'd0);
        @(negedge clk);
        check("t5_y9", y_w[0], 16'h0200);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_y",     y_w[0], 16'h0000);
        check("t5_rst_busy",  {15'd0, busy_w[0]},  16'd0);
        check("t5_rst_done",  {15'd0, done_w[0]},  16'd0);
        check("t5_rst_ready", {15'd0, ready_w[0]}, 16'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("t5_state_idle", {14'd0, st_w[0]}, 16'd0);
        check("t5_ready",      {15'd0, ready_w[0]}, 16'd1);

        // Disabled output, then code 2.
        drive(0, 0, 4'd0);
        @(negedge clk);
`ifdef DECODER_TRISTATE_EN
        check("t6_y_dis", y_w[0], 16'hzzzz);
`else
        check("t6_y_dis", y_w[0], 16'h0000);
`endif
        drive(1, 1, 4'd2);
        drive(1, 0, 4'd0);
        @(negedge clk);
        check("t6_y2", y_w[0], 16'h0004);
        wait_idle();

        // Randomised traffic, occasional enable drops.
        repeat (400) begin
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)));
        end
        drive(1, 0, 4'd0);
        wait_idle();

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
